// File: rtl/mon_tx_arbiter.sv
// mon_tx_arbiter
//   Collects fixed-width packets from CH source channels, each into its own
//   one-entry holding slot, plus an optional audio-request packet, and sends
//   them one at a time on a single serial line. Each frame is one start bit
//   (low), PKT_W data bits MSB first, then GAP_CYC idle-high cycles. Every bit
//   lasts BIT_CYC clock cycles.
//
//   Handshake: in_valid[k] is a one-cycle offer of in_data slice k. in_ready[k]
//   is high while slot k is empty. An offer into a full slot is dropped and
//   flagged in data_loss[k], unless that slot is handed to the shifter in the
//   same cycle, in which case the offer refills the slot.
//
// Ports
//   mon_clk    : clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : CH*PKT_W, channel k packet in bits [k*PKT_W +: PKT_W]
//   in_valid   : CH, one-cycle offer pulse per channel
//   in_ready   : CH, high when the channel's slot is empty
//   req_mode   : enables audio sample requests
//   req_tick   : one-cycle audio request strobe
//   loss_clr   : one-cycle pulse clearing all data_loss bits
//   from_mon   : registered serial output, idle high
//   busy       : high whenever a frame is in progress (FSM not IDLE)
//   data_loss  : CH+1 sticky drop flags, bit CH is the audio-request flag
//   dbg_state  : current FSM state (IDLE=0, START=1, DATA=2, GAP=3)

module mon_tx_arbiter #(
    parameter int                CH          = 3,
    parameter int                PKT_W       = 40,
    parameter int                BIT_CYC     = 1,
    parameter int                GAP_CYC     = 4,
    parameter logic [PKT_W-1:0]  REQ_PATTERN = '0
) (
    input  logic                  mon_clk,
    input  logic                  rst_n,
    input  logic [CH*PKT_W-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic                  req_mode,
    input  logic                  req_tick,
    input  logic                  loss_clr,
    output logic                  from_mon,
    output logic                  busy,
    output logic [CH:0]           data_loss,
    output logic [1:0]            dbg_state
);

    localparam int CNT_MAX = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(PKT_W + 1);
    localparam int LW      = $clog2(CH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [BW-1:0] PKT_LAST  = BW'(PKT_W - 1);
    localparam logic [LW-1:0] LAST_INIT = LW'(CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cyc;
    logic [BW-1:0]       r_bit;
    logic [PKT_W-1:0]    r_shift;
    logic                r_line;
    logic [CH-1:0]       r_full;
    logic [PKT_W-1:0]    r_slot [CH];
    logic                r_pend;
    logic [LW-1:0]       r_last;
    logic [CH:0]         r_loss;

    state_t              w_nxt_state;
    logic [CW-1:0]       w_nxt_cyc;
    logic [BW-1:0]       w_nxt_bit;
    logic [PKT_W-1:0]    w_nxt_shift;
    logic                w_nxt_line;

    logic                w_pick_req;
    logic                w_found;
    logic [CH-1:0]       w_pick_ch;
    logic [LW-1:0]       w_pick_idx;
    logic                w_grant;
    logic [PKT_W-1:0]    w_load;
    logic [CH:0]         w_loss_set;

    // Arbitration: only evaluated in IDLE. A pending audio request beats any
    // channel; channels are scanned round-robin starting after the last
    // channel that was granted.
    always_comb begin
        w_pick_req = 1'b0;
        w_found    = 1'b0;
        w_pick_ch  = '0;
        w_pick_idx = r_last;
        if (r_state == S_IDLE) begin
            if (r_pend) begin
                w_pick_req = 1'b1;
            end else begin
                for (int i = 1; i <= CH; i++) begin
                    if (!w_found && r_full[(int'(r_last) + i) % CH]) begin
                        w_found    = 1'b1;
                        w_pick_idx = LW'((int'(r_last) + i) % CH);
                        w_pick_ch[(int'(r_last) + i) % CH] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_grant = w_pick_req | w_found;
    assign w_load  = w_pick_req ? REQ_PATTERN : r_slot[w_pick_idx];

    // A new offer into a full slot is lost unless that slot is being drained
    // this very cycle; the same rule applies to the single request flag.
    always_comb begin
        w_loss_set = '0;
        for (int k = 0; k < CH; k++) begin
            w_loss_set[k] = in_valid[k] & r_full[k] & ~w_pick_ch[k];
        end
        w_loss_set[CH] = req_tick & req_mode & r_pend & ~w_pick_req;
    end

    // Frame sequencer next state. The serial line register is loaded from the
    // next state so that from_mon goes low in the first cycle of START.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cyc   = r_cyc;
        w_nxt_bit   = r_bit;
        w_nxt_shift = r_shift;
        w_nxt_line  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_nxt_state = S_START;
                    w_nxt_cyc   = '0;
                    w_nxt_shift = w_load;
                end
            end
            S_START: begin
                if (r_cyc == BIT_LAST) begin
                    w_nxt_state = S_DATA;
                    w_nxt_cyc   = '0;
                    w_nxt_bit   = '0;
                end else begin
                    w_nxt_cyc = r_cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cyc == BIT_LAST) begin
                    w_nxt_cyc = '0;
                    if (r_bit == PKT_LAST) begin
                        w_nxt_state = S_GAP;
                    end else begin
                        w_nxt_bit   = r_bit + 1'b1;
                        w_nxt_shift = {r_shift[PKT_W-2:0], 1'b0};
                    end
                end else begin
                    w_nxt_cyc = r_cyc + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cyc == GAP_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cyc   = '0;
                end else begin
                    w_nxt_cyc = r_cyc + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cyc   = '0;
            end
        endcase
        case (w_nxt_state)
            S_START: w_nxt_line = 1'b0;
            S_DATA:  w_nxt_line = w_nxt_shift[PKT_W-1];
            default: w_nxt_line = 1'b1;
        endcase
    end

    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_cyc   <= w_nxt_cyc;
            r_bit   <= w_nxt_bit;
            r_shift <= w_nxt_shift;
            r_line  <= w_nxt_line;
        end
    end

    // Holding slots: a granted slot is freed, and an offer in the same cycle
    // refills it.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
            for (int k = 0; k < CH; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (in_valid[k] && (!r_full[k] || w_pick_ch[k])) begin
                    r_full[k] <= 1'b1;
                    r_slot[k] <= in_data[k*PKT_W +: PKT_W];
                end else if (w_pick_ch[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    // Request flag, round-robin pointer and sticky loss flags. A loss event
    // coinciding with loss_clr leaves its bit set.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_last <= LAST_INIT;
            r_loss <= '0;
        end else begin
            if (req_tick && req_mode) begin
                r_pend <= 1'b1;
            end else if (w_pick_req) begin
                r_pend <= 1'b0;
            end
            if (w_found) begin
                r_last <= w_pick_idx;
            end
            r_loss <= (loss_clr ? '0 : r_loss) | w_loss_set;
        end
    end

    assign in_ready  = ~r_full;
    assign from_mon  = r_line;
    assign busy      = (r_state != S_IDLE);
    assign data_loss = r_loss;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mon_tx_arbiter.sv
// Bench for mon_tx_arbiter with CH=3, PKT_W=40, BIT_CYC=2, GAP_CYC=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mon_tx_arbiter;

  localparam int CH      = 3;
  localparam int PKT_W   = 40;
  localparam int BIT_CYC = 2;
  localparam int GAP_CYC = 4;
  localparam logic [PKT_W-1:0] REQ_PAT = 40'hC35A960FE1;

  // ---------------- clock / reset ----------------
  logic              mon_clk = 1'b0;
  logic              rst_n;
  logic [CH*PKT_W-1:0] in_data = '0;
  logic [CH-1:0]     in_valid = '0;
  logic              req_mode = 1'b0;
  logic              req_tick = 1'b0;
  logic              loss_clr = 1'b0;
  logic [CH-1:0]     in_ready;
  logic              from_mon;
  logic              busy;
  logic [CH:0]       data_loss;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 mon_clk = ~mon_clk;
  always @(posedge mon_clk) cyc <= cyc + 1;

  mon_tx_arbiter #(
    .CH(CH), .PKT_W(PKT_W), .BIT_CYC(BIT_CYC), .GAP_CYC(GAP_CYC), .REQ_PATTERN(REQ_PAT)
  ) dut (
    .mon_clk(mon_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .req_mode(req_mode), .req_tick(req_tick), .loss_clr(loss_clr),
    .from_mon(from_mon), .busy(busy), .data_loss(data_loss), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PKT_W-1:0];
  endfunction

  // ---------------- reference model ----------------
  // Frames are expanded into a queue of line samples at grant time; the line
  // and busy expectations are simply the head of that queue.
  logic [CH-1:0]    m_full = '0;
  logic [PKT_W-1:0] m_data [CH];
  logic             m_pend = 1'b0;
  int               m_last = CH - 1;
  logic [CH:0]      m_loss = '0;
  logic [CH:0]      m_set;
  logic             m_line = 1'b1;
  logic             m_busy = 1'b0;
  logic             m_greq;
  int               m_gch;
  logic [PKT_W-1:0] m_pkt;
  bit               frame_q[$];

  always @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = '0;
      m_pend = 1'b0;
      m_last = CH - 1;
      m_loss = '0;
      m_line = 1'b1;
      m_busy = 1'b0;
      frame_q.delete();
    end else begin
      m_greq = 1'b0;
      m_gch  = -1;
      m_pkt  = '0;
      if (!m_busy) begin
        if (m_pend) m_greq = 1'b1;
        else begin
          for (int i = 1; i <= CH; i++)
            if (m_gch < 0 && m_full[(m_last + i) % CH]) m_gch = (m_last + i) % CH;
        end
      end
      if (m_greq) begin
        m_pkt  = REQ_PAT;
        m_pend = 1'b0;
      end else if (m_gch >= 0) begin
        m_pkt = m_data[m_gch];
        m_full[m_gch] = 1'b0;
        m_last = m_gch;
      end
      m_set = '0;
      for (int k = 0; k < CH; k++) begin
        if (in_valid[k]) begin
          if (m_full[k]) m_set[k] = 1'b1;
          else begin
            m_full[k] = 1'b1;
            m_data[k] = in_data[k*PKT_W +: PKT_W];
          end
        end
      end
      if (req_tick && req_mode) begin
        if (m_pend) m_set[CH] = 1'b1;
        else m_pend = 1'b1;
      end
      m_loss = (loss_clr ? '0 : m_loss) | m_set;
      if (m_greq || m_gch >= 0) begin
        repeat (BIT_CYC) frame_q.push_back(1'b0);
        for (int b = PKT_W - 1; b >= 0; b--) repeat (BIT_CYC) frame_q.push_back(m_pkt[b]);
        repeat (GAP_CYC) frame_q.push_back(1'b1);
      end
      if (frame_q.size() > 0) begin
        m_line = frame_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_line = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge mon_clk) begin
    check("line", {63'b0, from_mon}, {63'b0, m_line});
    check("busy", {63'b0, busy}, {63'b0, m_busy});
    check("in_ready", {61'b0, in_ready}, {61'b0, ~m_full});
    check("data_loss", {60'b0, data_loss}, {60'b0, m_loss});
  end

  // ---------------- line receiver ----------------
  logic [PKT_W-1:0] rx_q[$];
  int               rx_t[$];
  logic             rx_prev = 1'b1;

  initial begin : rx_proc
    logic [PKT_W-1:0] d;
    int t;
    forever begin
      @(negedge mon_clk);
      if (rst_n && rx_prev && !from_mon) begin
        t = cyc;
        d = '0;
        repeat (BIT_CYC - 1) @(negedge mon_clk);
        for (int i = 0; i < PKT_W; i++) begin
          repeat (BIT_CYC) @(negedge mon_clk);
          d = {d[PKT_W-2:0], from_mon};
        end
        rx_q.push_back(d);
        rx_t.push_back(t);
      end
      rx_prev = from_mon;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = '0;
    req_tick = 1'b0;
    loss_clr = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [PKT_W-1:0] d);
    in_valid[k] = 1'b1;
    in_data[k*PKT_W +: PKT_W] = d;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    int q = 0;
    while (q < 4 && n < budget) begin
      @(negedge mon_clk);
      n++;
      if (!busy && in_ready == {CH{1'b1}}) q++;
      else q = 0;
    end
    check("wait_quiet_timeout", {63'b0, (q >= 4)}, 64'd1);
  endtask

  task automatic wait_rx(input int cnt, input int budget);
    int n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      @(negedge mon_clk);
      n++;
    end
    check("wait_rx_timeout", {63'b0, (rx_q.size() >= cnt)}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge mon_clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge mon_clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [PKT_W-1:0] pkt;
    logic [7:0] head;
    int tp;
    int lows;
    int rate;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_line", {63'b0, from_mon}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {61'b0, in_ready}, 64'h7);
    check("rst_loss", {60'b0, data_loss}, 64'h0);
    repeat (3) @(negedge mon_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge mon_clk);

    // All three slots filled together: round-robin from reset pointer.
    clear_rx();
    @(negedge mon_clk);
    tp = cyc;
    set_ch(0, 40'h1122334455);
    set_ch(1, 40'h66778899AA);
    set_ch(2, 40'hBBCCDDEEFF);
    @(negedge mon_clk);
    idle_inputs();
    wait_rx(3, 400);
    check("rr_first", {24'b0, rx_q[0]}, {24'b0, 40'h1122334455});
    check("rr_second", {24'b0, rx_q[1]}, {24'b0, 40'h66778899AA});
    check("rr_third", {24'b0, rx_q[2]}, {24'b0, 40'hBBCCDDEEFF});
    check("rr_latency", rx_t[0] - tp, 64'd2);
    check("rr_spacing_01", rx_t[1] - rx_t[0], 64'd87);
    check("rr_spacing_12", rx_t[2] - rx_t[1], 64'd87);
    wait_quiet(300);

    // Single frame on channel 1, checked sample by sample.
    pkt  = 40'hA500000001;
    head = 8'b1010_0101;
    @(negedge mon_clk);
    set_ch(1, pkt);
    @(negedge mon_clk);
    idle_inputs();
    check("t1_idle_before_start", {63'b0, from_mon}, 64'd1);
    check("t1_busy_before_start", {63'b0, busy}, 64'd0);
    for (int j = 0; j < BIT_CYC; j++) begin
      @(negedge mon_clk);
      check("t1_start_bit", {63'b0, from_mon}, 64'd0);
      check("t1_busy", {63'b0, busy}, 64'd1);
    end
    for (int i = 0; i < PKT_W; i++) begin
      for (int j = 0; j < BIT_CYC; j++) begin
        @(negedge mon_clk);
        if (i < 8) check("t1_head_bit", {63'b0, from_mon}, {63'b0, head[7-i]});
        else check("t1_data_bit", {63'b0, from_mon}, {63'b0, pkt[PKT_W-1-i]});
      end
    end
    for (int j = 0; j < GAP_CYC; j++) begin
      @(negedge mon_clk);
      check("t1_gap", {63'b0, from_mon}, 64'd1);
    end
    @(negedge mon_clk);
    check("t1_busy_after", {63'b0, busy}, 64'd0);
    check("t1_loss", {60'b0, data_loss}, 64'h0);
    wait_quiet(100);

    // Audio request together with channel 2: request wins.
    clear_rx();
    @(negedge mon_clk);
    req_mode = 1'b1;
    req_tick = 1'b1;
    set_ch(2, 40'h0F1E2D3C4B);
    @(negedge mon_clk);
    idle_inputs();
    wait_rx(2, 300);
    check("req_first", {24'b0, rx_q[0]}, {24'b0, REQ_PAT});
    check("req_then_ch2", {24'b0, rx_q[1]}, {24'b0, 40'h0F1E2D3C4B});
    check("req_spacing", rx_t[1] - rx_t[0], 64'd87);
    check("req_loss", {60'b0, data_loss}, 64'h0);
    wait_quiet(300);

    // Overrun on slot 0 while a channel 1 frame is in flight.
    clear_rx();
    @(negedge mon_clk);
    set_ch(1, 40'h5555AAAA33);
    @(negedge mon_clk);
    idle_inputs();
    repeat (4) @(negedge mon_clk);
    set_ch(0, 40'h0123456789);
    @(negedge mon_clk);
    idle_inputs();
    @(negedge mon_clk);
    set_ch(0, 40'hDEADBEEF00);
    @(negedge mon_clk);
    idle_inputs();
    @(negedge mon_clk);
    set_ch(0, 40'hFEEDFACE11);
    @(negedge mon_clk);
    idle_inputs();
    check("ovr_busy", {63'b0, busy}, 64'd1);
    check("ovr_loss", {60'b0, data_loss}, 64'h1);
    wait_rx(2, 300);
    check("ovr_frame_ch1", {24'b0, rx_q[0]}, {24'b0, 40'h5555AAAA33});
    check("ovr_kept_first", {24'b0, rx_q[1]}, {24'b0, 40'h0123456789});
    check("ovr_loss_sticky", {60'b0, data_loss}, 64'h1);
    @(negedge mon_clk);
    loss_clr = 1'b1;
    @(negedge mon_clk);
    idle_inputs();
    check("ovr_loss_cleared", {60'b0, data_loss}, 64'h0);
    wait_quiet(300);

    // Reset in the middle of data bit 20.
    clear_rx();
    pkt = 40'h3C3C3C3C3C;
    @(negedge mon_clk);
    set_ch(0, pkt);
    @(negedge mon_clk);
    idle_inputs();
    set_ch(2, 40'h7777777777);
    @(negedge mon_clk);
    idle_inputs();
    check("rst_mid_start", {63'b0, from_mon}, 64'd0);
    repeat (BIT_CYC + 20 * BIT_CYC) @(negedge mon_clk);
    check("rst_mid_bit20", {63'b0, from_mon}, {63'b0, pkt[PKT_W-1-20]});
    check("rst_mid_slot2_full", {61'b0, in_ready}, 64'h3);
    @(posedge mon_clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_line", {63'b0, from_mon}, 64'd1);
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_ready", {61'b0, in_ready}, 64'h7);
    check("rst_mid_loss", {60'b0, data_loss}, 64'h0);
    repeat (3) @(negedge mon_clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge mon_clk);
      if (!from_mon || busy) lows++;
    end
    check("rst_no_frame_after", lows, 64'd0);
    clear_rx();
    @(negedge mon_clk);
    set_ch(1, 40'h9876543210);
    @(negedge mon_clk);
    idle_inputs();
    wait_rx(1, 200);
    check("rst_new_frame", {24'b0, rx_q[0]}, {24'b0, 40'h9876543210});
    wait_quiet(300);

    // Randomized traffic, heavy then light, checked by the model every cycle.
    req_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rate = (c < 1500) ? 4 : 1;
      @(negedge mon_clk);
      for (int k = 0; k < CH; k++) begin
        in_valid[k] = ($urandom_range(0, 99) < rate);
        in_data[k*PKT_W +: PKT_W] = rnd_pkt();
      end
      req_tick = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 199) == 0) req_mode = ~req_mode;
      loss_clr = ($urandom_range(0, 99) == 0);
    end
    @(negedge mon_clk);
    idle_inputs();
    wait_quiet(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
